// File: rtl/axi_sram_bridge.sv
// AXI4 slave to single-port SRAM bridge serving one INCR word burst at a time.
// Optional macro AXI_SRAM_BRIDGE_SLVERR_EN: beats beyond RAM_SIZE answer SLVERR instead of wrapping.
module axi_sram_bridge #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int RAM_SIZE       = 32768,
  parameter int OFFSET_WIDTH   = 20,
  localparam int MEM_ADDR_WIDTH = $clog2(RAM_SIZE/4)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      aw_valid,
  output logic                      aw_ready,
  input  logic [AXI_ADDR_WIDTH-1:0] aw_addr,
  input  logic [7:0]                aw_len,
  input  logic [AXI_ID_WIDTH-1:0]   aw_id,
  input  logic                      w_valid,
  output logic                      w_ready,
  input  logic [AXI_DATA_WIDTH-1:0] w_data,
  input  logic [3:0]                w_strb,
  input  logic                      w_last,
  output logic                      b_valid,
  input  logic                      b_ready,
  output logic [AXI_ID_WIDTH-1:0]   b_id,
  output logic [1:0]                b_resp,
  input  logic                      ar_valid,
  output logic                      ar_ready,
  input  logic [AXI_ADDR_WIDTH-1:0] ar_addr,
  input  logic [7:0]                ar_len,
  input  logic [AXI_ID_WIDTH-1:0]   ar_id,
  output logic                      r_valid,
  input  logic                      r_ready,
  output logic [AXI_DATA_WIDTH-1:0] r_data,
  output logic [1:0]                r_resp,
  output logic [AXI_ID_WIDTH-1:0]   r_id,
  output logic                      r_last,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [AXI_DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]                mem_be,
  input  logic [AXI_DATA_WIDTH-1:0] mem_rdata,
  output logic [1:0]                dbg_state
);

  localparam int WORD_W = OFFSET_WIDTH - 2;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_WRESP = 2'd2;
  localparam logic [1:0] S_READ  = 2'd3;

  // Handshake rule on every channel: a transfer happens on a rising clk edge
  // where valid and ready are both high; valid never waits on ready.

  logic [1:0]                r_state;
  logic                      r_prio_w;
  logic [WORD_W-1:0]         r_word;
  logic [7:0]                r_cnt;
  logic                      r_rdone;
  logic [AXI_ID_WIDTH-1:0]   r_id_b;
  logic [AXI_ID_WIDTH-1:0]   r_id_r;
  logic                      r_werr;
  logic                      r_infl;
  logic                      r_infl_last;
  logic                      r_infl_err;
  logic [AXI_DATA_WIDTH-1:0] r_buf_data [2];
  logic                      r_buf_last [2];
  logic                      r_buf_err  [2];
  logic                      r_wptr;
  logic                      r_rptr;
  logic [1:0]                r_bcnt;

  logic       w_idle;
  logic       w_aw_grant;
  logic       w_ar_grant;
  logic       w_oob;
  logic       w_wbeat;
  logic       w_pop;
  logic [2:0] w_occ;
  logic       w_rissue;

  assign w_idle     = (r_state == S_IDLE);
  assign w_aw_grant = w_idle && aw_valid && (!ar_valid || r_prio_w);
  assign w_ar_grant = w_idle && ar_valid && (!aw_valid || !r_prio_w);

`ifdef AXI_SRAM_BRIDGE_SLVERR_EN
  // The word counter keeps the full offset, so anything past the RAM is visible here.
  assign w_oob = (32'(r_word) >= 32'(RAM_SIZE/4));
`else
  assign w_oob = 1'b0;
`endif

  assign w_wbeat  = (r_state == S_WRITE) && w_valid;
  assign w_pop    = r_valid && r_ready;
  // A beat leaving this cycle frees its slot, which keeps reads at one per cycle.
  assign w_occ    = {2'b00, r_infl} + {1'b0, r_bcnt} - {2'b00, w_pop};
  assign w_rissue = (r_state == S_READ) && !r_rdone && (w_occ < 3'd2);

  assign aw_ready  = w_aw_grant;
  assign ar_ready  = w_ar_grant;
  assign w_ready   = (r_state == S_WRITE);
  assign b_valid   = (r_state == S_WRESP);
  assign b_id      = r_id_b;
  assign b_resp    = {r_werr, 1'b0};
  assign r_valid   = (r_bcnt != 2'd0);
  assign r_data    = r_buf_data[r_rptr];
  assign r_last    = r_buf_last[r_rptr];
  assign r_resp    = {r_buf_err[r_rptr], 1'b0};
  assign r_id      = r_id_r;
  assign mem_req   = (w_wbeat || w_rissue) && !w_oob;
  assign mem_we    = (r_state == S_WRITE);
  assign mem_addr  = r_word[MEM_ADDR_WIDTH-1:0];
  assign mem_wdata = mem_we ? w_data : '0;
  assign mem_be    = mem_we ? w_strb : 4'b0000;
  assign dbg_state = r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_prio_w      <= 1'b1;
      r_word        <= '0;
      r_cnt         <= '0;
      r_rdone       <= 1'b1;
      r_id_b        <= '0;
      r_id_r        <= '0;
      r_werr        <= 1'b0;
      r_infl        <= 1'b0;
      r_infl_last   <= 1'b0;
      r_infl_err    <= 1'b0;
      r_buf_data[0] <= '0;
      r_buf_data[1] <= '0;
      r_buf_last[0] <= 1'b0;
      r_buf_last[1] <= 1'b0;
      r_buf_err[0]  <= 1'b0;
      r_buf_err[1]  <= 1'b0;
      r_wptr        <= 1'b0;
      r_rptr        <= 1'b0;
      r_bcnt        <= 2'd0;
    end else begin
      r_infl      <= w_rissue;
      r_infl_last <= w_rissue && (r_cnt == 8'd0);
      r_infl_err  <= w_rissue && w_oob;
      // SRAM data is valid the cycle after the request; capture it then.
      if (r_infl) begin
        r_buf_data[r_wptr] <= r_infl_err ? '0 : mem_rdata;
        r_buf_last[r_wptr] <= r_infl_last;
        r_buf_err[r_wptr]  <= r_infl_err;
        r_wptr             <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      r_bcnt <= r_bcnt + {1'b0, r_infl} - {1'b0, w_pop};

      case (r_state)
        S_IDLE: begin
          if (w_aw_grant) begin
            r_state  <= S_WRITE;
            r_word   <= aw_addr[OFFSET_WIDTH-1:2];
            r_cnt    <= aw_len;
            r_id_b   <= aw_id;
            r_werr   <= 1'b0;
            r_prio_w <= 1'b0;
          end else if (w_ar_grant) begin
            r_state  <= S_READ;
            r_word   <= ar_addr[OFFSET_WIDTH-1:2];
            r_cnt    <= ar_len;
            r_id_r   <= ar_id;
            r_rdone  <= 1'b0;
            r_prio_w <= 1'b1;
          end
        end
        S_WRITE: begin
          if (w_wbeat) begin
            r_word <= r_word + 1'b1;
            r_werr <= r_werr || w_oob;
            if (r_cnt == 8'd0) begin
              r_state <= S_WRESP;
            end else begin
              r_cnt <= r_cnt - 8'd1;
            end
          end
        end
        S_WRESP: begin
          if (b_ready) begin
            r_state <= S_IDLE;
          end
        end
        S_READ: begin
          if (w_rissue) begin
            r_word <= r_word + 1'b1;
            if (r_cnt == 8'd0) begin
              r_rdone <= 1'b1;
            end else begin
              r_cnt <= r_cnt - 8'd1;
            end
          end
          if (w_pop && r_last) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_sram_bridge.sv
// Randomized scoreboard bench for axi_sram_bridge with a transaction-level RAM model.
// Honours AXI_SRAM_BRIDGE_SLVERR_EN when defined for the whole build.
module tb_axi_sram_bridge;

  localparam int RAM_WORDS = 8192;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        aw_valid, aw_ready;
  logic [31:0] aw_addr;
  logic [7:0]  aw_len;
  logic [3:0]  aw_id;
  logic        w_valid, w_ready;
  logic [31:0] w_data;
  logic [3:0]  w_strb;
  logic        w_last;
  logic        b_valid, b_ready;
  logic [3:0]  b_id;
  logic [1:0]  b_resp;
  logic        ar_valid, ar_ready;
  logic [31:0] ar_addr;
  logic [7:0]  ar_len;
  logic [3:0]  ar_id;
  logic        r_valid, r_ready;
  logic [31:0] r_data;
  logic [1:0]  r_resp;
  logic [3:0]  r_id;
  logic        r_last;
  logic        mem_req, mem_we;
  logic [12:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic [1:0]  dbg_state;

  axi_sram_bridge dut (
    .clk(clk), .rst_n(rst_n),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr), .aw_len(aw_len), .aw_id(aw_id),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb), .w_last(w_last),
    .b_valid(b_valid), .b_ready(b_ready), .b_id(b_id), .b_resp(b_resp),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_len(ar_len), .ar_id(ar_id),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp), .r_id(r_id), .r_last(r_last),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset / environment ----------------
  always #5 clk = ~clk;

  logic [31:0] sram    [RAM_WORDS];
  logic [31:0] ref_mem [RAM_WORDS];

  always @(posedge clk) begin
    if (mem_req) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= sram[mem_addr];
      end
    end
  end

  int total = 0;
  int bad   = 0;
  int rr_mode = 0;
  int rr_cnt  = 0;
  int r_beats = 0;
  int b_cnt   = 0;
  int mw_cnt  = 0;
  int rd_total = 0;
  int rd_issue = 0;
  int r_ok     = 0;
  logic [12:0] last_raddr;

  logic [38:0] r_exp_q [$];
  logic [5:0]  b_exp_q [$];
  logic [48:0] mw_exp_q [$];
  logic        g_obs_q [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s timed out", name);
  endtask

  // Reference address rule: word offset from addr[19:2], +1 per beat.
  function automatic void model_word(input logic [31:0] addr, input int i,
                                     output logic [12:0] idx, output bit err);
    logic [17:0] w;
    w = 18'(32'(addr[19:2]) + 32'(i));
`ifdef AXI_SRAM_BRIDGE_SLVERR_EN
    err = (32'(w) >= RAM_WORDS);
`else
    err = 1'b0;
`endif
    idx = 13'(32'(w) % RAM_WORDS);
  endfunction

  // ---------------- r_ready driver ----------------
  initial begin
    r_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      rr_cnt++;
      case (rr_mode)
        0: r_ready = 1'b1;
        1: r_ready = (rr_cnt % 3 == 0);
        2: r_ready = 1'($urandom_range(0, 1));
        default: r_ready = 1'b0;
      endcase
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_write(input logic [31:0] addr, input int len, input logic [3:0] id,
                          input bit fixed, input logic [31:0] fd, input logic [3:0] fs, input bit gaps);
    logic [31:0] wd [256];
    logic [3:0]  ws [256];
    logic [12:0] idx;
    bit err, werr;
    int n;
    werr = 1'b0;
    for (int i = 0; i <= len; i++) begin
      wd[i] = fixed ? fd : $urandom;
      ws[i] = fixed ? fs : 4'($urandom_range(0, 15));
      model_word(addr, i, idx, err);
      if (err) werr = 1'b1;
      else begin
        mw_exp_q.push_back({idx, wd[i], ws[i]});
        for (int b = 0; b < 4; b++)
          if (ws[i][b]) ref_mem[idx][8*b +: 8] = wd[i][8*b +: 8];
      end
    end
    b_exp_q.push_back({werr ? 2'b10 : 2'b00, id});
    aw_addr = addr; aw_len = 8'(len); aw_id = id; aw_valid = 1'b1;
    n = 0;
    while (n < 1000) begin @(negedge clk); if (aw_ready) break; n++; end
    if (n >= 1000) timeout("aw_wait");
    @(posedge clk); #1 aw_valid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        w_valid = 1'b0;
        @(posedge clk); #1;
      end
      w_data = wd[i]; w_strb = ws[i]; w_last = (i == len); w_valid = 1'b1;
      n = 0;
      while (n < 100) begin @(negedge clk); if (w_ready) break; n++; end
      if (n >= 100) timeout("w_wait");
      @(posedge clk); #1;
    end
    w_valid = 1'b0; w_last = 1'b0;
    @(negedge clk);
    chk("b_valid_after_last_beat", b_valid, 1);
    @(posedge clk);
    repeat ($urandom_range(0, 3)) @(posedge clk);
    #1 b_ready = 1'b1;
    n = 0;
    while (n < 100) begin @(negedge clk); if (b_valid) break; n++; end
    if (n >= 100) timeout("b_wait");
    @(posedge clk); #1 b_ready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr, input int len, input logic [3:0] id, input bit chk_lat);
    logic [12:0] idx;
    bit err;
    int n, target, lat;
    for (int i = 0; i <= len; i++) begin
      model_word(addr, i, idx, err);
      r_exp_q.push_back({(i == len), err ? 2'b10 : 2'b00, err ? 32'h0 : ref_mem[idx], id});
    end
    target = r_beats + len + 1;
    ar_addr = addr; ar_len = 8'(len); ar_id = id; ar_valid = 1'b1;
    n = 0;
    while (n < 1000) begin @(negedge clk); if (ar_ready) break; n++; end
    if (n >= 1000) timeout("ar_wait");
    @(posedge clk); #1 ar_valid = 1'b0;
    if (chk_lat) begin
      lat = 0;
      while (lat < 20) begin @(negedge clk); if (r_valid) break; lat++; end
      chk("r_first_latency", lat, 2);
      for (int i = 0; i < len; i++) begin
        @(negedge clk);
        chk("r_back_to_back", r_valid, 1);
      end
    end
    n = 0;
    while (r_beats < target && n < 5000) begin @(negedge clk); n++; end
    if (r_beats < target) timeout("r_wait");
    @(posedge clk); #1;
  endtask

  // ---------------- monitors / scoreboard ----------------
  initial begin
    logic [38:0] re;
    logic [5:0]  be;
    logic [48:0] me;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rd_issue = 0;
        r_ok = 0;
      end else begin
        if (aw_valid && aw_ready) g_obs_q.push_back(1'b1);
        if (ar_valid && ar_ready) g_obs_q.push_back(1'b0);
        if (r_valid && r_ready) begin
          r_beats++;
          if (r_resp == 2'b00) r_ok++;
          if (r_exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL r_unexpected act=%0h", {r_last, r_resp, r_data, r_id});
          end else begin
            re = r_exp_q.pop_front();
            chk("r_beat{last,resp,data,id}", {r_last, r_resp, r_data, r_id}, re);
          end
        end
        if (b_valid && b_ready) begin
          b_cnt++;
          if (b_exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL b_unexpected act=%0h", {b_resp, b_id});
          end else begin
            be = b_exp_q.pop_front();
            chk("b_resp{resp,id}", {b_resp, b_id}, be);
          end
        end
        if (mem_req && mem_we) begin
          mw_cnt++;
          if (mw_exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL mem_write_unexpected addr=%0h", mem_addr);
          end else begin
            me = mw_exp_q.pop_front();
            chk("mem_write{addr,data,be}", {mem_addr, mem_wdata, mem_be}, me);
          end
        end
        if (mem_req && !mem_we) begin
          rd_issue++;
          rd_total++;
          last_raddr = mem_addr;
        end
        if (mem_req || r_valid)
          chk("reads_outstanding_le2", (rd_issue - r_ok) <= 2, 1);
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int n0, n1, len, op, wordo, nexp;
    logic [31:0] addr;

    for (int i = 0; i < RAM_WORDS; i++) begin
      sram[i] = $urandom;
      ref_mem[i] = sram[i];
    end
    rst_n = 1'b0;
    aw_valid = 0; aw_addr = 0; aw_len = 0; aw_id = 0;
    w_valid = 0; w_data = 0; w_strb = 0; w_last = 0;
    b_ready = 0;
    ar_valid = 0; ar_addr = 0; ar_len = 0; ar_id = 0;
    repeat (3) @(negedge clk);
    chk("rst_w_ready", w_ready, 0);
    chk("rst_b_valid", b_valid, 0);
    chk("rst_r_valid", r_valid, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_ready_pair", {aw_ready, ar_ready}, 0);
    chk("rst_resps_ids", {b_resp, r_resp, b_id, r_id}, 0);
    chk("rst_r_data", r_data, 0);
    chk("rst_mem_bus", {mem_we, mem_addr, mem_wdata, mem_be}, 0);
    chk("rst_state", dbg_state, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // simultaneous requests right after reset: write wins, then read
    g_obs_q.delete();
    fork
      do_write(32'h0000_0100, 2, 4'd3, 1'b0, 32'h0, 4'h0, 1'b0);
      do_read(32'h0000_0200, 1, 4'd9, 1'b0);
    join
    chk("arb1_grants", g_obs_q.size(), 2);
    if (g_obs_q.size() == 2) chk("arb1_order_WR", {g_obs_q[0], g_obs_q[1]}, 2'b10);

    // single write beat with partial strobe
    n0 = mw_cnt;
    do_write(32'h0000_0010, 0, 4'd5, 1'b1, 32'hDEAD_BEEF, 4'b0011, 1'b0);
    chk("single_write_count", mw_cnt - n0, 1);

    // last grant was a write: read now has priority
    g_obs_q.delete();
    fork
      do_write(32'h0000_0300, 1, 4'd1, 1'b0, 32'h0, 4'h0, 1'b1);
      do_read(32'h0000_0400, 2, 4'd2, 1'b0);
    join
    chk("arb2_grants", g_obs_q.size(), 2);
    if (g_obs_q.size() == 2) chk("arb2_order_RW", {g_obs_q[0], g_obs_q[1]}, 2'b01);

    for (int i = 0; i < 4; i++) begin
      sram[i] = 32'h10 + i;
      ref_mem[i] = 32'h10 + i;
    end
    rr_mode = 0;
    do_read(32'h0, 3, 4'd7, 1'b1);
    rr_mode = 1;
    do_read(32'h0, 3, 4'd8, 1'b0);

    // 256-beat write starting two words below the top of the RAM
    n0 = mw_cnt; n1 = b_cnt;
    do_write(32'h0000_7FF8, 255, 4'd12, 1'b0, 32'h0, 4'h0, 1'b0);
`ifdef AXI_SRAM_BRIDGE_SLVERR_EN
    nexp = 2;
`else
    nexp = 256;
`endif
    chk("long_burst_mem_writes", mw_cnt - n0, nexp);
    chk("long_burst_b_count", b_cnt - n1, 1);
    rr_mode = 2;
    do_read(32'h0000_7FF8, 255, 4'd13, 1'b0);

    // read one byte past the RAM
    rr_mode = 0;
    n0 = rd_total;
    do_read(32'h0000_8000, 0, 4'd4, 1'b0);
`ifdef AXI_SRAM_BRIDGE_SLVERR_EN
    chk("oob_read_no_mem_req", rd_total - n0, 0);
`else
    chk("wrap_read_one_req", rd_total - n0, 1);
    chk("wrap_read_addr", last_raddr, 0);
`endif

    for (int t = 0; t < 24; t++) begin
      op = $urandom_range(0, 1);
      len = $urandom_range(0, 15);
      wordo = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2*RAM_WORDS-1) : $urandom_range(0, RAM_WORDS-1);
      addr = {12'($urandom), 20'(wordo * 4)} | 32'($urandom_range(0, 3));
      rr_mode = $urandom_range(0, 2);
      if (op == 1) do_write(addr, len, 4'($urandom_range(0, 15)), 1'b0, 32'h0, 4'h0, 1'b1);
      else         do_read(addr, len, 4'($urandom_range(0, 15)), 1'b0);
    end

    // reset in the middle of a read burst: abandoned, no response
    rr_mode = 3;
    @(posedge clk); #1;
    ar_addr = 32'h40; ar_len = 8'd7; ar_id = 4'd6; ar_valid = 1'b1;
    n0 = 0;
    while (n0 < 100) begin @(negedge clk); if (ar_ready) break; n0++; end
    if (n0 >= 100) timeout("ar_wait_midreset");
    @(posedge clk); #1 ar_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_r_valid", r_valid, 0);
    chk("midrst_mem_req", mem_req, 0);
    chk("midrst_state", dbg_state, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    rr_mode = 0;
    do_read(32'h0000_0100, 2, 4'd10, 1'b1);

    repeat (4) @(posedge clk);
    chk("r_queue_drained", r_exp_q.size(), 0);
    chk("b_queue_drained", b_exp_q.size(), 0);
    chk("mw_queue_drained", mw_exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
